// File: rtl/f_stage.sv
// f_stage -- fetch stage of the 5-stage MIPS pipeline.
//
// Holds the program counter and picks the next fetch address from these
// sources, highest priority first: reset, exception entry, stall hold,
// eret return, taken branch/jump, sequential. It also flags fetch-address
// errors (AdEL) and counts the instructions handed to the D stage.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   stall               hazard stall from D; holds the PC
//   Req                 exception/interrupt request from CP0
//   D_eret, EPC         eret in D and its return address
//   D_jump_take         branch/jump in D resolved taken
//   D_jump_target       target of that branch/jump
//   D_is_jump           instruction in D is any branch/jump
//   i_inst_addr         instruction-memory address (= F_pc)
//   i_inst_rdata        instruction-memory read data (combinational)
//   F_instr, F_pc, F_pc8, F_ExcCode, F_BD   inputs of the D-stage register
//   fetch_cnt           number of instructions handed to D (wraps)
module f_stage #(
  parameter logic [31:0] PC_RESET  = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter logic [31:0] TEXT_LO   = 32'h0000_3000,
  parameter logic [31:0] TEXT_HI   = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        Req,
  input  logic        D_eret,
  input  logic [31:0] EPC,
  input  logic        D_jump_take,
  input  logic [31:0] D_jump_target,
  input  logic        D_is_jump,
  output logic [31:0] i_inst_addr,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] F_instr,
  output logic [31:0] F_pc,
  output logic [31:0] F_pc8,
  output logic [4:0]  F_ExcCode,
  output logic        F_BD,
  output logic [31:0] fetch_cnt
);

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  logic [31:0] pc_reg;
  logic [31:0] cnt_reg;
  logic [31:0] pc_next;
  logic        adel;

  // Next-PC selection. Req must beat stall so an exception is never lost
  // behind a hazard; a stalled eret or jump is simply re-presented by D
  // on a later cycle. eret is checked before the jump so that an illegal
  // eret+jump combination still returns to EPC.
  always_comb begin
    pc_next = pc_reg + 32'd4;
    if (Req) begin
      pc_next = EXC_ENTRY;
    end else if (stall) begin
      pc_next = pc_reg;
    end else if (D_eret) begin
      pc_next = EPC;
    end else if (D_jump_take) begin
      pc_next = D_jump_target;
    end
  end

  // PC register and retired-fetch counter. An instruction counts as
  // handed to D whenever the D register actually loads it, i.e. neither
  // stalled nor flushed by an exception; faulting fetches count too.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg  <= PC_RESET;
      cnt_reg <= 32'd0;
    end else begin
      pc_reg <= pc_next;
      if (!stall && !Req) begin
        cnt_reg <= cnt_reg + 32'd1;
      end
    end
  end

  // Fetch-address check: misaligned or outside the text segment. A
  // faulting fetch hands a nop downstream so nothing but the exception
  // code travels with it.
  always_comb begin
    adel = (pc_reg[1:0] != 2'b00) || (pc_reg < TEXT_LO) || (pc_reg > TEXT_HI);
    if (adel) begin
      F_ExcCode = EXC_ADEL;
      F_instr   = 32'h0000_0000;
    end else begin
      F_ExcCode = EXC_NONE;
      F_instr   = i_inst_rdata;
    end
  end

  // Whatever sits in F while a branch/jump is in D is its delay slot.
  assign F_BD        = D_is_jump;
  assign F_pc        = pc_reg;
  assign F_pc8       = pc_reg + 32'd8;
  assign i_inst_addr = pc_reg;
  assign fetch_cnt   = cnt_reg;

endmodule

// File: tb/tb_f_stage.sv
// tb_f_stage -- directed bench for the fetch stage. Inputs are driven
// right after a rising edge and outputs are sampled 1 time unit later,
// well away from the next edge. Expected values are hand-computed.
module tb_f_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        Req;
  logic        D_eret;
  logic [31:0] EPC;
  logic        D_jump_take;
  logic [31:0] D_jump_target;
  logic        D_is_jump;
  logic [31:0] i_inst_addr;
  logic [31:0] i_inst_rdata;
  logic [31:0] F_instr;
  logic [31:0] F_pc;
  logic [31:0] F_pc8;
  logic [4:0]  F_ExcCode;
  logic        F_BD;
  logic [31:0] fetch_cnt;

  int checkCount;
  int errorCount;

  f_stage dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .Req          (Req),
    .D_eret       (D_eret),
    .EPC          (EPC),
    .D_jump_take  (D_jump_take),
    .D_jump_target(D_jump_target),
    .D_is_jump    (D_is_jump),
    .i_inst_addr  (i_inst_addr),
    .i_inst_rdata (i_inst_rdata),
    .F_instr      (F_instr),
    .F_pc         (F_pc),
    .F_pc8        (F_pc8),
    .F_ExcCode    (F_ExcCode),
    .F_BD         (F_BD),
    .fetch_cnt    (fetch_cnt)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Set the control inputs, then advance one rising edge and settle.
  task automatic applyStimulus(input logic rst, input logic stl, input logic rq,
                               input logic eret, input logic [31:0] epc,
                               input logic take, input logic [31:0] tgt,
                               input logic isj);
    reset         = rst;
    stall         = stl;
    Req           = rq;
    D_eret        = eret;
    EPC           = epc;
    D_jump_take   = take;
    D_jump_target = tgt;
    D_is_jump     = isj;
    @(posedge clk);
    #1;
  endtask

  // Drop every control input back to idle without clocking.
  task automatic idleInputs();
    reset = 1'b0; stall = 1'b0; Req = 1'b0; D_eret = 1'b0;
    EPC = 32'h0; D_jump_take = 1'b0; D_jump_target = 32'h0; D_is_jump = 1'b0;
    #1;
  endtask

  // Checks PC-derived outputs and the counter in one go.
  task automatic checkPc(input string tag, input logic [31:0] pc,
                         input logic [31:0] cnt);
    checkOutput({tag, ".pc"},   F_pc, pc);
    checkOutput({tag, ".addr"}, i_inst_addr, pc);
    checkOutput({tag, ".pc8"},  F_pc8, pc + 32'd8);
    checkOutput({tag, ".cnt"},  fetch_cnt, cnt);
  endtask

  initial begin
    checkCount   = 0;
    errorCount   = 0;
    i_inst_rdata = 32'h2408_0001;

    // reset
    applyStimulus(1, 0, 0, 0, 32'h0, 0, 32'h0, 0);
    idleInputs();
    checkOutput("rst.pc",    F_pc, 32'h0000_3000);
    checkOutput("rst.pc8",   F_pc8, 32'h0000_3008);
    checkOutput("rst.addr",  i_inst_addr, 32'h0000_3000);
    checkOutput("rst.cnt",   fetch_cnt, 32'd0);
    checkOutput("rst.exc",   {27'd0, F_ExcCode}, 32'd0);
    checkOutput("rst.bd",    {31'd0, F_BD}, 32'd0);
    checkOutput("rst.instr", F_instr, 32'h2408_0001);

    // sequential fetch
    applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0, 0);
    checkPc("seq1", 32'h0000_3004, 32'd1);
    applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0, 0);
    checkPc("seq2", 32'h0000_3008, 32'd2);
    i_inst_rdata = 32'hDEAD_BEEF;
    #1;
    checkOutput("seq2.instr", F_instr, 32'hDEAD_BEEF);

    // stall 3 cycles at 0x3008; a stalled jump must be ignored
    applyStimulus(0, 1, 0, 0, 32'h0, 0, 32'h0, 0);
    checkPc("stall1", 32'h0000_3008, 32'd2);
    applyStimulus(0, 1, 0, 0, 32'h0, 1, 32'h0000_3100, 1);
    checkPc("stall2", 32'h0000_3008, 32'd2);
    applyStimulus(0, 1, 0, 0, 32'h0, 0, 32'h0, 0);
    checkPc("stall3", 32'h0000_3008, 32'd2);
    applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0, 0);
    checkPc("unstall", 32'h0000_300C, 32'd3);
    applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0, 0);
    checkPc("seq5", 32'h0000_3010, 32'd4);

    // branch not taken at 0x3010: delay slot flagged, sequential next
    idleInputs();
    D_is_jump = 1'b1;
    #1;
    checkOutput("nt.bd", {31'd0, F_BD}, 32'd1);
    applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0, 1);
    checkPc("nt", 32'h0000_3014, 32'd5);

    // branch taken at 0x3014 to 0x3100
    applyStimulus(0, 0, 0, 0, 32'h0, 1, 32'h0000_3100, 1);
    checkPc("jmp", 32'h0000_3100, 32'd6);
    idleInputs();
    checkOutput("jmp.bd0", {31'd0, F_BD}, 32'd0);

    // Req beats stall and jump; counter holds
    applyStimulus(0, 1, 1, 0, 32'h0, 1, 32'h0000_3200, 1);
    checkPc("req", 32'h0000_4180, 32'd6);
    idleInputs();
    checkOutput("req.exc", {27'd0, F_ExcCode}, 32'd0);

    // eret to 0x3020
    applyStimulus(0, 0, 0, 1, 32'h0000_3020, 0, 32'h0, 0);
    checkPc("eret", 32'h0000_3020, 32'd7);

    // eret together with a taken jump: eret wins
    applyStimulus(0, 0, 0, 1, 32'h0000_3040, 1, 32'h0000_3100, 1);
    checkPc("eretjmp", 32'h0000_3040, 32'd8);

    // stalled eret is ignored
    applyStimulus(0, 1, 0, 1, 32'h0000_5000, 0, 32'h0, 0);
    checkPc("stleret", 32'h0000_3040, 32'd8);

    // misaligned fetch
    applyStimulus(0, 0, 0, 1, 32'h0000_3022, 0, 32'h0, 0);
    idleInputs();
    checkPc("mis", 32'h0000_3022, 32'd9);
    checkOutput("mis.exc",   {27'd0, F_ExcCode}, 32'd4);
    checkOutput("mis.instr", F_instr, 32'h0);

    // above the text segment
    applyStimulus(0, 0, 0, 1, 32'h0000_7000, 0, 32'h0, 0);
    idleInputs();
    checkOutput("hi.exc",   {27'd0, F_ExcCode}, 32'd4);
    checkOutput("hi.instr", F_instr, 32'h0);
    checkOutput("hi.cnt",   fetch_cnt, 32'd10);

    // below the text segment
    applyStimulus(0, 0, 0, 1, 32'h0000_2FFC, 0, 32'h0, 0);
    idleInputs();
    checkOutput("lo.exc", {27'd0, F_ExcCode}, 32'd4);
    checkOutput("lo.cnt", fetch_cnt, 32'd11);

    // highest legal address
    applyStimulus(0, 0, 0, 1, 32'h0000_6FFC, 0, 32'h0, 0);
    idleInputs();
    checkPc("top", 32'h0000_6FFC, 32'd12);
    checkOutput("top.exc",   {27'd0, F_ExcCode}, 32'd0);
    checkOutput("top.instr", F_instr, 32'hDEAD_BEEF);

    // PC and PC+8 wrap modulo 2^32
    applyStimulus(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0, 0);
    idleInputs();
    checkPc("wrap", 32'hFFFF_FFFC, 32'd13);
    checkOutput("wrap.exc", {27'd0, F_ExcCode}, 32'd4);
    applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0, 0);
    checkPc("wrap2", 32'h0000_0000, 32'd14);
    checkOutput("wrap2.exc", {27'd0, F_ExcCode}, 32'd4);

    // Req beats eret
    applyStimulus(0, 0, 1, 1, 32'h0000_3020, 0, 32'h0, 0);
    checkPc("reqeret", 32'h0000_4180, 32'd14);

    // reset while stalled and requesting
    applyStimulus(1, 1, 1, 0, 32'h0, 0, 32'h0, 0);
    idleInputs();
    checkPc("rst2", 32'h0000_3000, 32'd0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
